// File: rtl/mdom_scdb_hdr_serializer.sv
// mdom_scdb_hdr_serializer
//   Accepts one packed SCDB waveform header per handshake and streams it to
//   the readout FIFO as OUT_W-bit words, least-significant word first.
//   Also exposes the held header's channel index and a wrapping count of
//   fully transmitted headers.
//   Optional feature macro: MDOM_SCDB_HDR_XSUM_EN appends one XOR-checksum
//   word after the data words of every header.
module mdom_scdb_hdr_serializer #(
  parameter  int unsigned LTC_W   = 49,
  parameter  int unsigned ADDR_W  = 12,
  parameter  int unsigned BSUM_W  = 19,
  parameter  int unsigned CHAN_W  = 5,
  parameter  int unsigned OUT_W   = 16,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned HDR_W   = LTC_W + 2*ADDR_W + BSUM_W + CHAN_W + 16,
  localparam int unsigned N_WORDS = (HDR_W + OUT_W - 1) / OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HDR_W-1:0]  in_bundle,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CHAN_W-1:0] hdr_chan,
  output logic [CNT_W-1:0]  hdr_cnt
);

  localparam int unsigned EXT_W = N_WORDS * OUT_W;
  localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_XSUM = 2'd2
  } state_t;

  state_t            r_state;
  logic [EXT_W-1:0]  r_held;
  logic [IDX_W-1:0]  r_word_idx;
  logic              r_out_valid;
  logic              r_out_last;
  logic [CHAN_W-1:0] r_chan;
  logic [CNT_W-1:0]  r_cnt;

  logic [EXT_W-1:0]  w_ext;
  logic              w_done;
  logic              w_in_ready;
  logic              w_load;
  logic              w_first_last;

  // Header zero-extended to a whole number of words so the pad bits read as 0.
  assign w_ext = EXT_W'(in_bundle);

`ifdef MDOM_SCDB_HDR_XSUM_EN
  logic [OUT_W-1:0] r_xsum;
  logic [OUT_W-1:0] w_xsum;

  // XOR of all data words of the header presented on in_bundle.
  always_comb begin
    w_xsum = '0;
    for (int unsigned i = 0; i < N_WORDS; i++) begin
      w_xsum = w_xsum ^ w_ext[i*OUT_W +: OUT_W];
    end
  end

  assign w_first_last = 1'b0;
`else
  assign w_first_last = (LAST_IDX == '0);
`endif

  // Final word of a header leaves this cycle; frees the holding register.
  assign w_done     = r_out_valid & out_ready & r_out_last;
  assign w_in_ready = (r_state == ST_IDLE) | w_done;
  assign w_load     = in_valid & w_in_ready;

  // Header state machine: load, word-by-word shift-out, optional checksum word.
  // The held header shifts down one word per transfer so out_data is always
  // the low word of a register rather than a wide mux on word_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_held      <= '0;
      r_word_idx  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_chan      <= '0;
      r_cnt       <= '0;
`ifdef MDOM_SCDB_HDR_XSUM_EN
      r_xsum      <= '0;
`endif
    end else begin
      if (w_done) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_load) begin
        r_state     <= ST_SEND;
        r_held      <= w_ext;
        r_word_idx  <= '0;
        r_out_valid <= 1'b1;
        r_out_last  <= w_first_last;
        r_chan      <= in_bundle[HDR_W-1 -: CHAN_W];
`ifdef MDOM_SCDB_HDR_XSUM_EN
        r_xsum      <= w_xsum;
`endif
      end else if (w_done) begin
        r_state     <= ST_IDLE;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else if ((r_state == ST_SEND) && out_ready) begin
`ifdef MDOM_SCDB_HDR_XSUM_EN
        if (r_word_idx == LAST_IDX) begin
          r_state    <= ST_XSUM;
          r_held     <= EXT_W'(r_xsum);
          r_out_last <= 1'b1;
        end else begin
          r_held     <= r_held >> OUT_W;
          r_word_idx <= r_word_idx + 1'b1;
        end
`else
        r_held     <= r_held >> OUT_W;
        r_word_idx <= r_word_idx + 1'b1;
        r_out_last <= ((r_word_idx + 1'b1) == LAST_IDX);
`endif
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_held[OUT_W-1:0];
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign hdr_chan  = r_chan;
  assign hdr_cnt   = r_cnt;

endmodule

// File: tb/tb_mdom_scdb_hdr_serializer.sv
// Testbench for mdom_scdb_hdr_serializer: directed and randomized headers
// checked against a word-list reference model built from the header layout.
module tb_mdom_scdb_hdr_serializer;

  localparam int HDR_W = 113;
  localparam int NW    = 8;
`ifdef MDOM_SCDB_HDR_XSUM_EN
  localparam int WPH   = NW + 1;
`else
  localparam int WPH   = NW;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [HDR_W-1:0] in_bundle;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [4:0]       hdr_chan;
  logic [15:0]      hdr_cnt;

  logic [HDR_W-1:0] in_bundle2;
  logic             in_valid2;
  logic             in_ready2;
  logic [15:0]      out_data2;
  logic             out_valid2;
  logic             out_ready2;
  logic             out_last2;
  logic [4:0]       hdr_chan2;
  logic [1:0]       hdr_cnt2;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mdom_scdb_hdr_serializer u_dut (
    .clk(clk), .rst(rst), .in_bundle(in_bundle), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .hdr_chan(hdr_chan),
    .hdr_cnt(hdr_cnt)
  );

  mdom_scdb_hdr_serializer #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_bundle(in_bundle2), .in_valid(in_valid2),
    .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_last(out_last2), .hdr_chan(hdr_chan2),
    .hdr_cnt(hdr_cnt2)
  );

  // Reference: header zero-extended to 128 bits, cut into 16-bit words LSW
  // first, optionally followed by the XOR of those words.
  task automatic model_words(input logic [HDR_W-1:0] b);
    logic [127:0] ext;
    logic [15:0]  x;
    ext = {15'b0, b};
    x = '0;
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      exp_q.push_back(ext[i*16 +: 16]);
      x = x ^ ext[i*16 +: 16];
    end
`ifdef MDOM_SCDB_HDR_XSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  function automatic logic [HDR_W-1:0] rand_bundle();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[HDR_W-1:0];
  endfunction

  // Send one header from idle; mode 0: out_ready=1, 1: random, 2: 1,0,0,1 pattern.
  task automatic run_hdr(input logic [HDR_W-1:0] b, input int mode);
    int k;
    int guard;
    logic rdy;
    logic [4:0] chan;
    chan = b[HDR_W-1 -: 5];
    model_words(b);
    in_bundle = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    guard = 0;
    while (k < exp_q.size() && guard < 200) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== exp_q[k] ||
          out_last !== (k == exp_q.size() - 1) || hdr_chan !== chan) begin
        n_err++;
        $display("FAIL word%0d got v=%b d=%h l=%b ch=%h want v=1 d=%h l=%b ch=%h",
                 k, out_valid, out_data, out_last, hdr_chan, exp_q[k],
                 (k == exp_q.size() - 1), chan);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (guard % 4 == 0) || (guard % 4 == 3);
      endcase
      out_ready = rdy;
      #1;
      n_vec++;
      if (in_ready !== (rdy && (k == exp_q.size() - 1))) begin
        n_err++;
        $display("FAIL send_in_ready word%0d got %b want %b", k, in_ready,
                 (rdy && (k == exp_q.size() - 1)));
      end
      @(posedge clk); #1;
      if (rdy) k++;
      guard++;
    end
    out_ready = 1'b0;
    if (guard >= 200) begin
      n_err++;
      $display("FAIL timeout got %0d words want %0d", k, exp_q.size());
    end
    exp_cnt++;
    n_vec++;
    if (out_valid !== 1'b0 || hdr_cnt !== 16'(exp_cnt)) begin
      n_err++;
      $display("FAIL hdr_end got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, hdr_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_bundle = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_bundle2 = '0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 16'h0 ||
        hdr_chan !== 5'h0 || hdr_cnt !== 16'h0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset got v=%b l=%b d=%h ch=%h cnt=%h rdy=%b want 0,0,0,0,0,1",
               out_valid, out_last, out_data, hdr_chan, hdr_cnt, in_ready);
    end
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_ltc_pattern();
    logic [HDR_W-1:0] b;
    b = '0;
    b[48:0] = 49'h1_2345_6789_ABCD;
    run_hdr(b, 0);
  endtask

  task automatic test_chan_field();
    logic [HDR_W-1:0] b;
    b = '0;
    b[112:108] = 5'h1F;
    b[107] = 1'b1;
    run_hdr(b, 0);
    n_vec++;
    if (hdr_chan !== 5'h1F) begin
      n_err++;
      $display("FAIL chan_hold got %h want 1f", hdr_chan);
    end
  endtask

  task automatic test_all_ones();
    run_hdr({HDR_W{1'b1}}, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) run_hdr(rand_bundle(), 1);
  endtask

  task automatic test_stall_pattern();
    for (int i = 0; i < 2; i++) run_hdr(rand_bundle(), 2);
  endtask

  task automatic test_back_to_back();
    logic [HDR_W-1:0] a;
    logic [HDR_W-1:0] b;
    logic [15:0] all_q[$];
    logic [4:0] chan;
    a = rand_bundle();
    b = rand_bundle();
    all_q.delete();
    model_words(a);
    foreach (exp_q[i]) all_q.push_back(exp_q[i]);
    model_words(b);
    foreach (exp_q[i]) all_q.push_back(exp_q[i]);
    in_bundle = a; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_bundle = b;
    for (int j = 0; j < 2*WPH; j++) begin
      chan = (j < WPH) ? a[HDR_W-1 -: 5] : b[HDR_W-1 -: 5];
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== all_q[j] ||
          out_last !== (j % WPH == WPH - 1) || hdr_chan !== chan ||
          in_ready !== (j % WPH == WPH - 1)) begin
        n_err++;
        $display("FAIL b2b_word%0d got v=%b d=%h l=%b ch=%h rdy=%b want v=1 d=%h l=%b ch=%h rdy=%b",
                 j, out_valid, out_data, out_last, hdr_chan, in_ready, all_q[j],
                 (j % WPH == WPH - 1), chan, (j % WPH == WPH - 1));
      end
      @(posedge clk); #1;
      if (j == WPH - 1) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    exp_cnt += 2;
    n_vec++;
    if (out_valid !== 1'b0 || hdr_cnt !== 16'(exp_cnt)) begin
      n_err++;
      $display("FAIL b2b_end got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, hdr_cnt, exp_cnt);
    end
  endtask

  task automatic test_mid_reset();
    logic [HDR_W-1:0] b;
    b = rand_bundle();
    model_words(b);
    in_bundle = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== exp_q[k]) begin
        n_err++;
        $display("FAIL prerst_word%0d got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, exp_q[k]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    n_vec++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || hdr_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL midrst got v=%b l=%b cnt=%0d want v=0 l=0 cnt=0", out_valid, out_last, hdr_cnt);
    end
    run_hdr(rand_bundle(), 0);
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] e2;
    in_bundle2 = rand_bundle();
    in_valid2 = 1'b1;
    out_ready2 = 1'b1;
    @(posedge clk);
    for (int h = 0; h < 5; h++) begin
      repeat (WPH) @(posedge clk);
      #1;
      e2 = 2'(h + 1);
      n_vec++;
      if (hdr_cnt2 !== e2) begin
        n_err++;
        $display("FAIL cnt_wrap hdr%0d got %0d want %0d", h, hdr_cnt2, e2);
      end
      if (h == 3) in_valid2 = 1'b0;
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid2 !== 1'b0) begin
      n_err++;
      $display("FAIL cnt_wrap_idle got v=%b want 0", out_valid2);
    end
  endtask

  initial begin
    test_reset();
    test_ltc_pattern();
    test_chan_field();
    test_all_ones();
    test_random();
    test_stall_pattern();
    test_back_to_back();
    test_mid_reset();
    test_cnt_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
